pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Arbitrates cacheline-adapter (CLA) access among three masters: the instruction cache, the LSQ/data cache, and the next-line prefetcher. Drives a single physical-memory CLA port. Produces the `arbiter_idle` signal that the prefetcher uses to decide when it may issue. Sits between the caches/prefetcher and the cacheline adapter. One request is in flight at a time, and a grant is never preempted.

## Interface
Parameters:
- OFFSET_BITS, 5, line-offset width (32-byte lines). The CLA address has these bits forced to 0. Buffer tag is addr[31:OFFSET_BITS].

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- icache_pmem_read_cla  in  1  icache line read request
- icache_pmem_address_cla  in  32  icache line address
- icache_pmem_resp_cla  out  1  icache completion
- icache_pmem_rdata_256_cla  out  256  icache read line
- lsq_pmem_read_cla  in  1  LSQ line read request
- lsq_pmem_write_cla  in  1  LSQ line write request
- lsq_pmem_address_cla  in  32  LSQ line address
- lsq_pmem_wdata_256_cla  in  256  LSQ write line
- lsq_pmem_resp_cla  out  1  LSQ completion
- lsq_pmem_rdata_256_cla  out  256  LSQ read line
- pref_pmem_read_cla  in  1  prefetch read request
- pref_pmem_write_cla  in  1  ignored, never granted
- pref_pmem_address_cla  in  32  prefetch address
- pref_pmem_resp_cla  out  1  prefetch completion
- arbiter_idle  out  1  high in IDLE only
- cla_read  out  1  to adapter
- cla_write  out  1  to adapter
- cla_address  out  32  to adapter, line aligned
- cla_wdata_256  out  256  to adapter
- cla_resp  in  1  adapter completion
- cla_rdata_256  in  256  adapter read line

## Operation
- States: IDLE, BUSY, DONE, plus HIT (only when PREF_BUF_EN is defined).
- **IDLE**, grant selection:
  - Priority is demand over prefetch.
  - Between icache and LSQ, round-robin: the `last_demand` bit favours the master not granted last. Reset value of `last_demand` favours LSQ.
  - Prefetch is granted only when neither demand request is asserted.
- **On grant**, latch the following, then go to BUSY:
  - owner (I/D/P)
  - op: write iff LSQ and `lsq_pmem_write_cla`. If LSQ asserts read and write together, write wins.
  - address, with low OFFSET_BITS cleared
  - wdata
- **BUSY**:
  - `cla_read`/`cla_write`/`cla_address`/`cla_wdata_256` are driven from the latched registers only.
  - Hold until `cla_resp`.
  - On `cla_resp`, pulse the owner's `*_resp_cla` in the same cycle. For icache/LSQ reads, `*_rdata_256_cla` passes `cla_rdata_256` through. Then go to DONE.
- **DONE**: one dead cycle so masters can drop their request; then go to IDLE. No grant is made in DONE.
- `pref_pmem_write_cla` is never acted on.
- **Reset values**:
  - All outputs 0, except `arbiter_idle` = 1.
  - State IDLE; latched registers 0.
- **Reset mid-BUSY**: the transaction is abandoned immediately and the outputs return to their reset values. The adapter is reset with the same `rst`.
- `*_rdata_256_cla` are 0 whenever the matching resp is 0.

## Timing
- A request seen in IDLE at cycle N gives `cla_*` asserted at N+1.
- `cla_resp` at cycle M gives the owner's resp at M (combinational).
- DONE at M+1; IDLE (`arbiter_idle`=1) at M+2. The earliest next grant is decided at M+2 and issued at M+3.
- Minimum demand occupancy is 3 cycles plus adapter latency.
- `arbiter_idle` is registered state decode, low from N+1 through M+1.
- A master must hold request, address and wdata stable until its resp, and deassert in the cycle after resp.

## Configuration
- Macro: `PMEM_ARB_PREF_BUF_EN`.
- **Defined**: one-line prefetch buffer {valid, tag, 256-bit data}.
  - Capture:
    - Filled with `cla_rdata_256` when a prefetch completes.
    - valid is set.
  - Hit:
    - An LSQ read in IDLE whose tag matches a valid buffer takes the HIT state instead of BUSY.
    - No `cla_*` activity.
    - At N+1, `lsq_pmem_resp_cla`=1 and rdata = buffer data.
    - Then DONE.
    - The buffer stays valid.
  - Invalidation:
    - An LSQ write granted to a matching tag clears valid at grant.
    - Icache never looks up the buffer.
    - Reset clears valid.
- **Undefined**: no buffer and no HIT state. Prefetch read data is discarded; only `pref_pmem_resp_cla` pulses.

## Test plan
- **Single LSQ read**: LSQ read at 0x1000_0024, adapter resp after 4 cycles → `cla_address`=0x1000_0020 one cycle after request, LSQ resp same cycle as `cla_resp` with matching data, `arbiter_idle`=1 two cycles later.
- **Concurrent demand**: icache read and LSQ read asserted together from reset → LSQ granted first, icache second. Repeat both → LSQ, icache, LSQ, icache alternate.
- **Prefetch lowest priority**: prefetch read and icache read asserted together → icache served first, prefetch after. Prefetch write held high alone → no `cla_*` activity and `arbiter_idle` stays 1.
- **LSQ write precedence**: LSQ read=1, write=1, wdata=0xA5…A5 → `cla_write`=1, `cla_read`=0, `cla_wdata_256`=0xA5…A5.
- **Reset mid-BUSY**: rst low while BUSY → all outputs 0 and `arbiter_idle`=1 without waiting for the clock. After release, a new request is granted normally.
- **Prefetch buffer (PREF_BUF_EN)**:
  - Prefetch 0x2000_0040 completes, then LSQ read 0x2000_0048 → resp one cycle after request with no `cla_read`.
  - LSQ write 0x2000_0040 followed by LSQ read 0x2000_0040 → read goes to the adapter.

Source files
------------

// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Arbitrates the single cacheline-adapter (CLA) port among the icache,
//   the LSQ/data cache and the next-line prefetcher. One request is in flight
//   at a time and a grant is never preempted.
//
//   Optional feature macro: PMEM_ARB_PREF_BUF_EN
//     defined   -> one-line prefetch buffer; LSQ reads that hit it are
//                  answered from the buffer (HIT state) without the adapter.
//     undefined -> prefetch read data is discarded, only the resp pulses.
//
//   Ports
//     clk, rst                      clock, asynchronous active-low reset
//     icache_pmem_*_cla             icache line read request / completion
//     lsq_pmem_*_cla                LSQ line read/write request / completion
//     pref_pmem_*_cla               prefetch read request / completion
//     arbiter_idle                  high while in IDLE
//     cla_read/write/address/wdata  request towards the adapter
//     cla_resp, cla_rdata_256       completion from the adapter
//
//   state | meaning
//   IDLE  | no transaction, grant selection
//   BUSY  | latched request driven to the adapter, waiting for cla_resp
//   DONE  | dead cycle so the served master can drop its request
//   HIT   | LSQ read served from the prefetch buffer (buffer build only)

module pmem_arbiter #(
  parameter int OFFSET_BITS = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         icache_pmem_read_cla,
  input  logic [31:0]  icache_pmem_address_cla,
  output logic         icache_pmem_resp_cla,
  output logic [255:0] icache_pmem_rdata_256_cla,
  input  logic         lsq_pmem_read_cla,
  input  logic         lsq_pmem_write_cla,
  input  logic [31:0]  lsq_pmem_address_cla,
  input  logic [255:0] lsq_pmem_wdata_256_cla,
  output logic         lsq_pmem_resp_cla,
  output logic [255:0] lsq_pmem_rdata_256_cla,
  input  logic         pref_pmem_read_cla,
  input  logic         pref_pmem_write_cla,
  input  logic [31:0]  pref_pmem_address_cla,
  output logic         pref_pmem_resp_cla,
  output logic         arbiter_idle,
  output logic         cla_read,
  output logic         cla_write,
  output logic [31:0]  cla_address,
  output logic [255:0] cla_wdata_256,
  input  logic         cla_resp,
  input  logic [255:0] cla_rdata_256
);

  localparam int TAG_W = 32 - OFFSET_BITS;

`ifdef PMEM_ARB_PREF_BUF_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, HIT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`endif

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2, OWN_P = 2'd3} owner_t;

  state_t             state_q, state_d;
  owner_t             owner_q;
  logic               write_q;
  logic [TAG_W-1:0]   addr_q;
  logic [255:0]       wdata_q;
  // 1: icache was the last demand grant, so LSQ wins the next tie
  logic               last_demand;

  logic               lsq_req;
  logic               pick_lsq, pick_icache, pick_pref, grant_en;
  logic               lsq_hit;
  logic               busy, owner_done;
  logic [TAG_W-1:0]   grant_tag;

  assign lsq_req     = lsq_pmem_read_cla | lsq_pmem_write_cla;
  assign pick_lsq    = lsq_req && (!icache_pmem_read_cla || last_demand);
  assign pick_icache = icache_pmem_read_cla && !pick_lsq;
  assign pick_pref   = pref_pmem_read_cla && !icache_pmem_read_cla && !lsq_req;
  assign grant_en    = (state_q == IDLE) && (pick_lsq || pick_icache || pick_pref);

  always_comb begin
    grant_tag = '0;
    if (pick_lsq)         grant_tag = lsq_pmem_address_cla[31:OFFSET_BITS];
    else if (pick_icache) grant_tag = icache_pmem_address_cla[31:OFFSET_BITS];
    else if (pick_pref)   grant_tag = pref_pmem_address_cla[31:OFFSET_BITS];
  end

`ifdef PMEM_ARB_PREF_BUF_EN
  logic             buf_valid;
  logic [TAG_W-1:0] buf_tag;
  logic [255:0]     buf_data;
  logic             lsq_tag_match;

  assign lsq_tag_match = buf_valid && (lsq_pmem_address_cla[31:OFFSET_BITS] == buf_tag);
  assign lsq_hit       = pick_lsq && !lsq_pmem_write_cla && lsq_tag_match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (busy && owner_q == OWN_P && cla_resp) begin
      buf_valid <= 1'b1;
      buf_tag   <= addr_q;
      buf_data  <= cla_rdata_256;
    end else if (grant_en && pick_lsq && lsq_pmem_write_cla && lsq_tag_match) begin
      buf_valid <= 1'b0;
    end
  end
`else
  assign lsq_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_en) state_d = lsq_hit ? state_t'(2'd3) : BUSY;
      end
      BUSY: if (cla_resp) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = DONE;  // HIT answers in one cycle
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_demand <= 1'b1;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        owner_q <= pick_lsq ? OWN_D : (pick_icache ? OWN_I : OWN_P);
        write_q <= pick_lsq && lsq_pmem_write_cla;
        addr_q  <= grant_tag;
        wdata_q <= pick_lsq ? lsq_pmem_wdata_256_cla : '0;
        if (pick_lsq)    last_demand <= 1'b0;
        if (pick_icache) last_demand <= 1'b1;
      end
    end
  end

  assign busy       = (state_q == BUSY);
  assign owner_done = busy && cla_resp;

  assign arbiter_idle  = (state_q == IDLE);
  assign cla_read      = busy && !write_q;
  assign cla_write     = busy && write_q;
  assign cla_address   = busy ? {addr_q, {OFFSET_BITS{1'b0}}} : 32'h0;
  assign cla_wdata_256 = busy ? wdata_q : '0;

  assign icache_pmem_resp_cla      = owner_done && owner_q == OWN_I;
  assign icache_pmem_rdata_256_cla = icache_pmem_resp_cla ? cla_rdata_256 : '0;
  assign pref_pmem_resp_cla        = owner_done && owner_q == OWN_P;

`ifdef PMEM_ARB_PREF_BUF_EN
  assign lsq_pmem_resp_cla      = (owner_done && owner_q == OWN_D) || (state_q == HIT);
  assign lsq_pmem_rdata_256_cla = (state_q == HIT) ? buf_data :
                                  ((owner_done && owner_q == OWN_D && !write_q) ? cla_rdata_256 : '0);
`else
  assign lsq_pmem_resp_cla      = owner_done && owner_q == OWN_D;
  assign lsq_pmem_rdata_256_cla = (lsq_pmem_resp_cla && !write_q) ? cla_rdata_256 : '0;
`endif

  // line-offset bits and the prefetch write request carry no information here
  logic unused_bits;
  assign unused_bits = ^{pref_pmem_write_cla,
                         icache_pmem_address_cla[OFFSET_BITS-1:0],
                         lsq_pmem_address_cla[OFFSET_BITS-1:0],
                         pref_pmem_address_cla[OFFSET_BITS-1:0]};

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         icache_pmem_read_cla = 1'b0;
  logic [31:0]  icache_pmem_address_cla = '0;
  logic         icache_pmem_resp_cla;
  logic [255:0] icache_pmem_rdata_256_cla;
  logic         lsq_pmem_read_cla = 1'b0;
  logic         lsq_pmem_write_cla = 1'b0;
  logic [31:0]  lsq_pmem_address_cla = '0;
  logic [255:0] lsq_pmem_wdata_256_cla = '0;
  logic         lsq_pmem_resp_cla;
  logic [255:0] lsq_pmem_rdata_256_cla;
  logic         pref_pmem_read_cla = 1'b0;
  logic         pref_pmem_write_cla = 1'b0;
  logic [31:0]  pref_pmem_address_cla = '0;
  logic         pref_pmem_resp_cla;
  logic         arbiter_idle;
  logic         cla_read;
  logic         cla_write;
  logic [31:0]  cla_address;
  logic [255:0] cla_wdata_256;
  logic         cla_resp = 1'b0;
  logic [255:0] cla_rdata_256 = '0;

  int total = 0;
  int bad = 0;

  pmem_arbiter #(.OFFSET_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .icache_pmem_read_cla(icache_pmem_read_cla),
    .icache_pmem_address_cla(icache_pmem_address_cla),
    .icache_pmem_resp_cla(icache_pmem_resp_cla),
    .icache_pmem_rdata_256_cla(icache_pmem_rdata_256_cla),
    .lsq_pmem_read_cla(lsq_pmem_read_cla),
    .lsq_pmem_write_cla(lsq_pmem_write_cla),
    .lsq_pmem_address_cla(lsq_pmem_address_cla),
    .lsq_pmem_wdata_256_cla(lsq_pmem_wdata_256_cla),
    .lsq_pmem_resp_cla(lsq_pmem_resp_cla),
    .lsq_pmem_rdata_256_cla(lsq_pmem_rdata_256_cla),
    .pref_pmem_read_cla(pref_pmem_read_cla),
    .pref_pmem_write_cla(pref_pmem_write_cla),
    .pref_pmem_address_cla(pref_pmem_address_cla),
    .pref_pmem_resp_cla(pref_pmem_resp_cla),
    .arbiter_idle(arbiter_idle),
    .cla_read(cla_read), .cla_write(cla_write),
    .cla_address(cla_address), .cla_wdata_256(cla_wdata_256),
    .cla_resp(cla_resp), .cla_rdata_256(cla_rdata_256)
  );

  always #5 clk = ~clk;

  task automatic drop_all();
    icache_pmem_read_cla = 1'b0;
    lsq_pmem_read_cla = 1'b0;
    lsq_pmem_write_cla = 1'b0;
    pref_pmem_read_cla = 1'b0;
    pref_pmem_write_cla = 1'b0;
    cla_resp = 1'b0;
    cla_rdata_256 = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drop_all();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  // Acts as the adapter for one transaction: waits (bounded) for a request,
  // answers it immediately, reports which master saw the resp, then drops that
  // master's request in the following cycle. who=0 means nothing was granted.
  task automatic serve_one(input logic [255:0] data, output int who,
                           output logic [31:0] addr, output logic was_write,
                           output logic [255:0] rdata_seen);
    who = 0; addr = '0; was_write = 1'b0; rdata_seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (cla_read || cla_write) break;
    end
    if (!(cla_read || cla_write)) return;
    addr = cla_address;
    was_write = cla_write;
    cla_resp = 1'b1;
    cla_rdata_256 = data;
    #1;
    if (icache_pmem_resp_cla)   begin who = 1; rdata_seen = icache_pmem_rdata_256_cla; end
    else if (lsq_pmem_resp_cla) begin who = 2; rdata_seen = lsq_pmem_rdata_256_cla; end
    else if (pref_pmem_resp_cla) who = 3;
    @(negedge clk); #1;
    cla_resp = 1'b0;
    cla_rdata_256 = '0;
    if (who == 1) icache_pmem_read_cla = 1'b0;
    if (who == 2) begin lsq_pmem_read_cla = 1'b0; lsq_pmem_write_cla = 1'b0; end
    if (who == 3) pref_pmem_read_cla = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    total++;
    if (arbiter_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", arbiter_idle); end
    total++;
    if ({cla_read, cla_write, icache_pmem_resp_cla, lsq_pmem_resp_cla, pref_pmem_resp_cla} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000",
        {cla_read, cla_write, icache_pmem_resp_cla, lsq_pmem_resp_cla, pref_pmem_resp_cla});
    end
    total++;
    if (cla_address !== 32'h0 || cla_wdata_256 !== '0) begin
      bad++; $display("FAIL reset_addr got=%h want=0", cla_address);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_lsq_read();
    logic [255:0] d = {8{32'hCAFE_0001}};
    @(negedge clk); #1;
    lsq_pmem_read_cla = 1'b1;
    lsq_pmem_address_cla = 32'h1000_0024;
    @(negedge clk); #1;
    total++;
    if (cla_read !== 1'b1 || cla_address !== 32'h1000_0020) begin
      bad++; $display("FAIL single_issue got read=%b addr=%h want read=1 addr=10000020", cla_read, cla_address);
    end
    total++;
    if (arbiter_idle !== 1'b0) begin bad++; $display("FAIL single_busy_idle got=%b want=0", arbiter_idle); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++;
      if (lsq_pmem_resp_cla !== 1'b0 || cla_read !== 1'b1) begin
        bad++; $display("FAIL single_hold got resp=%b read=%b want resp=0 read=1", lsq_pmem_resp_cla, cla_read);
      end
    end
    @(negedge clk); #1;
    cla_resp = 1'b1;
    cla_rdata_256 = d;
    #1;
    total++;
    if (lsq_pmem_resp_cla !== 1'b1 || lsq_pmem_rdata_256_cla !== d || icache_pmem_resp_cla !== 1'b0) begin
      bad++; $display("FAIL single_resp got resp=%b rdata=%h want resp=1 rdata=%h",
        lsq_pmem_resp_cla, lsq_pmem_rdata_256_cla, d);
    end
    @(negedge clk); #1;
    cla_resp = 1'b0;
    cla_rdata_256 = '0;
    lsq_pmem_read_cla = 1'b0;
    #1;
    total++;
    if (arbiter_idle !== 1'b0 || cla_read !== 1'b0 || lsq_pmem_resp_cla !== 1'b0 || lsq_pmem_rdata_256_cla !== '0) begin
      bad++; $display("FAIL single_done got idle=%b read=%b resp=%b want 0 0 0",
        arbiter_idle, cla_read, lsq_pmem_resp_cla);
    end
    @(negedge clk); #1;
    total++;
    if (arbiter_idle !== 1'b1) begin bad++; $display("FAIL single_back_idle got=%b want=1", arbiter_idle); end
  endtask

  task automatic test_concurrent_demand();
    int who;
    logic [31:0] a;
    logic w;
    logic [255:0] rd;
    int exp_who[4] = '{2, 1, 2, 1};
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      icache_pmem_read_cla = 1'b1;
      icache_pmem_address_cla = 32'h0000_4004 + r;
      lsq_pmem_read_cla = 1'b1;
      lsq_pmem_address_cla = 32'h0000_8010;
      for (int k = 0; k < 2; k++) begin
        serve_one({8{32'h5000_0000 + r * 2 + k}}, who, a, w, rd);
        total++;
        if (who !== exp_who[r * 2 + k]) begin
          bad++; $display("FAIL rr_order step=%0d got=%0d want=%0d", r * 2 + k, who, exp_who[r * 2 + k]);
        end
        total++;
        if (rd !== {8{32'h5000_0000 + r * 2 + k}} ||
            a !== ((who == 2) ? 32'h0000_8000 : 32'h0000_4000)) begin
          bad++; $display("FAIL rr_data step=%0d got addr=%h rdata=%h", r * 2 + k, a, rd);
        end
      end
      total++;
      if (cla_read !== 1'b0) begin bad++; $display("FAIL rr_done_no_grant got=%b want=0", cla_read); end
    end
  endtask

  task automatic test_pref_priority();
    int who;
    logic [31:0] a;
    logic w;
    logic [255:0] rd;
    @(negedge clk); @(negedge clk); #1;
    icache_pmem_read_cla = 1'b1;
    icache_pmem_address_cla = 32'h0000_1000;
    pref_pmem_read_cla = 1'b1;
    pref_pmem_address_cla = 32'h0000_1020;
    serve_one({8{32'h1}}, who, a, w, rd);
    total++;
    if (who !== 1) begin bad++; $display("FAIL pref_first got=%0d want=1", who); end
    serve_one({8{32'h2}}, who, a, w, rd);
    total++;
    if (who !== 3 || a !== 32'h0000_1020) begin
      bad++; $display("FAIL pref_second got who=%0d addr=%h want who=3 addr=00001020", who, a);
    end
    @(negedge clk); #1;
    pref_pmem_write_cla = 1'b1;
    pref_pmem_address_cla = 32'h0000_2000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total++;
      if (cla_read !== 1'b0 || cla_write !== 1'b0 || arbiter_idle !== 1'b1) begin
        bad++; $display("FAIL pref_write_ignored cyc=%0d got rd=%b wr=%b idle=%b want 0 0 1",
          i, cla_read, cla_write, arbiter_idle);
      end
    end
    pref_pmem_write_cla = 1'b0;
  endtask

  task automatic test_lsq_write();
    int who;
    logic [31:0] a;
    logic w;
    logic [255:0] rd;
    logic [255:0] wd = {8{32'hA5A5_A5A5}};
    @(negedge clk); #1;
    lsq_pmem_read_cla = 1'b1;
    lsq_pmem_write_cla = 1'b1;
    lsq_pmem_address_cla = 32'h0000_C03F;
    lsq_pmem_wdata_256_cla = wd;
    @(negedge clk); #1;
    total++;
    if (cla_write !== 1'b1 || cla_read !== 1'b0 || cla_wdata_256 !== wd || cla_address !== 32'h0000_C020) begin
      bad++; $display("FAIL write_wins got wr=%b rd=%b addr=%h wdata=%h", cla_write, cla_read, cla_address, cla_wdata_256);
    end
    serve_one('0, who, a, w, rd);
    total++;
    if (who !== 2 || w !== 1'b1) begin bad++; $display("FAIL write_resp got who=%0d wr=%b want 2 1", who, w); end
    lsq_pmem_wdata_256_cla = '0;
  endtask

  task automatic test_reset_mid_busy();
    int who;
    logic [31:0] a;
    logic w;
    logic [255:0] rd;
    @(negedge clk); @(negedge clk); #1;
    icache_pmem_read_cla = 1'b1;
    icache_pmem_address_cla = 32'h3000_0000;
    @(negedge clk); #1;
    total++;
    if (cla_read !== 1'b1) begin bad++; $display("FAIL mid_busy_start got=%b want=1", cla_read); end
    cla_resp = 1'b1;
    rst = 1'b0;
    #1;
    total++;
    if (cla_read !== 1'b0 || cla_address !== 32'h0 || arbiter_idle !== 1'b1 || icache_pmem_resp_cla !== 1'b0) begin
      bad++; $display("FAIL mid_busy_reset got rd=%b addr=%h idle=%b resp=%b want 0 0 1 0",
        cla_read, cla_address, arbiter_idle, icache_pmem_resp_cla);
    end
    drop_all();
    @(negedge clk);
    rst = 1'b1;
    #1;
    lsq_pmem_read_cla = 1'b1;
    lsq_pmem_address_cla = 32'h0000_7777;
    serve_one({8{32'h7}}, who, a, w, rd);
    total++;
    if (who !== 2 || a !== 32'h0000_7760) begin
      bad++; $display("FAIL post_reset_grant got who=%0d addr=%h want 2 00007760", who, a);
    end
  endtask

`ifdef PMEM_ARB_PREF_BUF_EN
  task automatic test_pref_buf();
    int who;
    logic [31:0] a;
    logic w;
    logic [255:0] rd;
    logic [255:0] d = {8{32'hBEEF_0040}};
    @(negedge clk); @(negedge clk); #1;
    pref_pmem_read_cla = 1'b1;
    pref_pmem_address_cla = 32'h2000_0040;
    serve_one(d, who, a, w, rd);
    total++;
    if (who !== 3) begin bad++; $display("FAIL buf_fill got=%0d want=3", who); end
    @(negedge clk); #1;
    lsq_pmem_read_cla = 1'b1;
    lsq_pmem_address_cla = 32'h2000_0048;
    @(negedge clk); #1;
    total++;
    if (lsq_pmem_resp_cla !== 1'b1 || lsq_pmem_rdata_256_cla !== d || cla_read !== 1'b0) begin
      bad++; $display("FAIL buf_hit got resp=%b rd=%b rdata=%h", lsq_pmem_resp_cla, cla_read, lsq_pmem_rdata_256_cla);
    end
    lsq_pmem_read_cla = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    lsq_pmem_write_cla = 1'b1;
    lsq_pmem_address_cla = 32'h2000_0040;
    serve_one('0, who, a, w, rd);
    total++;
    if (who !== 2 || w !== 1'b1) begin bad++; $display("FAIL buf_write got who=%0d wr=%b", who, w); end
    @(negedge clk); #1;
    lsq_pmem_read_cla = 1'b1;
    lsq_pmem_address_cla = 32'h2000_0040;
    serve_one({8{32'h1234_5678}}, who, a, w, rd);
    total++;
    if (who !== 2 || w !== 1'b0 || rd !== {8{32'h1234_5678}}) begin
      bad++; $display("FAIL buf_invalidated got who=%0d wr=%b rdata=%h", who, w, rd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_lsq_read();
    test_concurrent_demand();
    test_pref_priority();
    test_lsq_write();
    test_reset_mid_busy();
`ifdef PMEM_ARB_PREF_BUF_EN
    test_pref_buf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
